// File: rtl/wb_daq_pkg.sv
// Shared types and constants for the DAQ channel scheduler.
package wb_daq_pkg;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_AW     = 32;
    localparam int unsigned DEF_LEN_W  = 16;
    // Buffer pointers count 32-bit words; byte address = ptr << WORD_SHIFT.
    localparam int unsigned WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

endpackage

// File: rtl/wb_daq_rr_picker.sv
// Combinational round-robin picker: first requester after last_sel, wrapping.
module wb_daq_rr_picker
    import wb_daq_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] request,
    input  logic [SEL_W-1:0]  last_sel,
    output logic [NUM_CH-1:0] grant_c,
    output logic [SEL_W-1:0]  select_c,
    output logic              valid_c
);

    // Scan last_sel+1 .. last_sel+NUM_CH (mod NUM_CH); first hit wins.
    always_comb begin
        logic [SEL_W-1:0] idx;
        grant_c  = '0;
        select_c = '0;
        valid_c  = 1'b0;
        idx      = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = SEL_W'((32'(last_sel) + i) % NUM_CH);
            if (!valid_c && request[idx]) begin
                valid_c       = 1'b1;
                grant_c[idx]  = 1'b1;
                select_c      = idx;
            end
        end
    end

endmodule

// File: rtl/wb_daq_channel_scheduler.sv
// Round-robin scheduler sharing one DAQ Wishbone bus master between ADC channels.
// Optional completion watchdog: define WB_DAQ_SCHED_TIMEOUT_EN.
module wb_daq_channel_scheduler
    import wb_daq_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned LEN_W   = DEF_LEN_W,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    input  logic                    master_enable,
    input  logic [NUM_CH-1:0]       request,
    input  logic [NUM_CH*AW-1:0]    base_addr,
    input  logic [NUM_CH*LEN_W-1:0] buf_words,
    input  logic                    xfer_done,
    input  logic                    xfer_err,
    input  logic [NUM_CH-1:0]       err_clr,
    output logic [NUM_CH-1:0]       grant,
    output logic [SEL_W-1:0]        select,
    output logic                    start,
    output logic [AW-1:0]           address,
    output logic [NUM_CH-1:0]       wrap,
    output logic [NUM_CH-1:0]       err_flag,
    output logic                    busy
);

    state_e            state_q;
    state_e            state_nxt;
    logic [SEL_W-1:0]  last_sel_q;
    logic [LEN_W-1:0]  ptr_q [NUM_CH];
    logic [LEN_W-1:0]  len_q;
    logic [AW-1:0]     base_arr [NUM_CH];
    logic [LEN_W-1:0]  len_arr [NUM_CH];
    logic [NUM_CH-1:0] pick_grant_c;
    logic [SEL_W-1:0]  pick_sel_c;
    logic              pick_valid_c;
    logic              launch_c;
    logic              finish_c;
    logic              fail_c;
    logic              timeout_c;
    logic [LEN_W-1:0]  last_idx_c;
    logic              wrap_hit_c;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign base_arr[g] = base_addr[g*AW +: AW];
        assign len_arr[g]  = buf_words[g*LEN_W +: LEN_W];
    end

    wb_daq_rr_picker #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_picker (
        .request  (request),
        .last_sel (last_sel_q),
        .grant_c  (pick_grant_c),
        .select_c (pick_sel_c),
        .valid_c  (pick_valid_c)
    );

    // A zero-length buffer behaves as length 1: pointer pinned at 0.
    assign last_idx_c = (len_q == '0) ? '0 : len_q - LEN_W'(1);
    assign wrap_hit_c = (ptr_q[select] >= last_idx_c);

`ifdef WB_DAQ_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q;

    // Cycles spent in WAIT; fires on the TIMEOUT-th WAIT cycle without completion.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign timeout_c = (state_q == ST_WAIT) && (to_cnt_q == TO_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign timeout_c      = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // State register.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and transfer events; an error (or timeout) outranks done.
    always_comb begin
        state_nxt = state_q;
        launch_c  = 1'b0;
        finish_c  = 1'b0;
        fail_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (master_enable && pick_valid_c) begin
                    launch_c  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (xfer_err || timeout_c) begin
                    fail_c    = 1'b1;
                    finish_c  = 1'b1;
                    state_nxt = ST_UPDATE;
                end else if (xfer_done) begin
                    finish_c  = 1'b1;
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs, per-channel pointers and sticky error flags.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            grant      <= '0;
            select     <= '0;
            start      <= 1'b0;
            address    <= '0;
            wrap       <= '0;
            err_flag   <= '0;
            busy       <= 1'b0;
            len_q      <= '0;
            last_sel_q <= SEL_W'(NUM_CH - 1);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            start    <= launch_c;
            busy     <= (state_nxt != ST_IDLE);
            wrap     <= '0;
            err_flag <= (err_flag & ~err_clr) | (fail_c ? grant : '0);
            if (launch_c) begin
                grant   <= pick_grant_c;
                select  <= pick_sel_c;
                len_q   <= len_arr[pick_sel_c];
                address <= base_arr[pick_sel_c] + (AW'(ptr_q[pick_sel_c]) << WORD_SHIFT);
            end
            if (finish_c) begin
                grant      <= '0;
                last_sel_q <= select;
                if (!fail_c) begin
                    if (wrap_hit_c) begin
                        ptr_q[select] <= '0;
                        wrap          <= grant;
                    end else begin
                        ptr_q[select] <= ptr_q[select] + LEN_W'(1);
                    end
                end
            end
            if ((state_q == ST_IDLE) && !master_enable) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    ptr_q[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_daq_channel_scheduler.sv
// Self-checking bench for wb_daq_channel_scheduler with a transfer-level reference model.
module tb_wb_daq_channel_scheduler;

    logic         wb_clk = 1'b0;
    logic         wb_rst_n;
    logic         master_enable;
    logic [3:0]   request;
    logic [127:0] base_addr;
    logic [63:0]  buf_words;
    logic         xfer_done;
    logic         xfer_err;
    logic [3:0]   err_clr;
    logic [3:0]   grant;
    logic [1:0]   select;
    logic         start;
    logic [31:0]  address;
    logic [3:0]   wrap;
    logic [3:0]   err_flag;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: sampled config, word pointers, last owner, error flags.
    int unsigned base_m [4];
    int unsigned len_m  [4];
    int unsigned ptr_m  [4];
    int          last_m;
    logic [3:0]  err_m;

    wb_daq_channel_scheduler #(
        .NUM_CH  (4),
        .SEL_W   (2),
        .AW      (32),
        .LEN_W   (16),
        .TIMEOUT (16)
    ) dut (
        .wb_clk        (wb_clk),
        .wb_rst_n      (wb_rst_n),
        .master_enable (master_enable),
        .request       (request),
        .base_addr     (base_addr),
        .buf_words     (buf_words),
        .xfer_done     (xfer_done),
        .xfer_err      (xfer_err),
        .err_clr       (err_clr),
        .grant         (grant),
        .select        (select),
        .start         (start),
        .address       (address),
        .wrap          (wrap),
        .err_flag      (err_flag),
        .busy          (busy)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (req[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_addr(input int ch);
        return 32'(base_m[ch] + ptr_m[ch] * 4);
    endfunction

    // Successful completion: wrap when the old pointer reached the last word.
    task automatic model_done(input int ch, output bit w);
        int unsigned lim;
        lim = (len_m[ch] == 0) ? 0 : len_m[ch] - 1;
        w = (ptr_m[ch] >= lim);
        ptr_m[ch] = w ? 0 : ptr_m[ch] + 1;
    endtask

    task automatic set_cfg(input int ch, input logic [31:0] b, input logic [15:0] l);
        base_addr[ch*32 +: 32] = b;
        buf_words[ch*16 +: 16] = l;
        base_m[ch] = b;
        len_m[ch]  = l;
    endtask

    task automatic do_reset();
        wb_rst_n      = 1'b0;
        master_enable = 1'b0;
        request       = '0;
        xfer_done     = 1'b0;
        xfer_err      = 1'b0;
        err_clr       = '0;
        repeat (3) @(negedge wb_clk);
        for (int i = 0; i < 4; i++) ptr_m[i] = 0;
        last_m   = 3;
        err_m    = '0;
        wb_rst_n = 1'b1;
    endtask

    // Waits for a start, then completes the transfer; returns what was observed
    // in the ISSUE cycle (grant/select/address) and the UPDATE cycle.
    task automatic run_xfer(input int dly, input bit d, input bit e, input logic [3:0] clr,
                            input bit drop_en, input bit perturb,
                            output bit ok, output logic [3:0] g, output logic [1:0] s,
                            output logic [31:0] a, output logic [3:0] w,
                            output logic [3:0] ef, output logic [3:0] gu);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge wb_clk);
            if (start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        g = grant; s = select; a = address; w = '0; ef = '0; gu = '0;
        if (ok) begin
            @(negedge wb_clk);
            if (drop_en) master_enable = 1'b0;
            if (perturb) begin
                base_addr = {$urandom, $urandom, $urandom, $urandom};
                buf_words = {$urandom, $urandom};
                request   = 4'($urandom);
            end
            repeat (dly - 1) @(negedge wb_clk);
            xfer_done = d;
            xfer_err  = e;
            err_clr   = clr;
            @(negedge wb_clk);
            xfer_done = 1'b0;
            xfer_err  = 1'b0;
            err_clr   = '0;
            w = wrap; ef = err_flag; gu = grant;
        end
    endtask

    task automatic test_reset();
        wb_rst_n = 1'b1;
        master_enable = 1'b0; request = '0; xfer_done = 1'b0; xfer_err = 1'b0; err_clr = '0;
        base_addr = '0; buf_words = '0;
        #1 wb_rst_n = 1'b0;
        repeat (2) @(negedge wb_clk);
        n_cmp++;
        if ({grant, select, start, wrap, err_flag, busy} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", {grant, select, start, wrap, err_flag, busy});
        end
        n_cmp++;
        if (address !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_address: got %h want 0", address);
        end
        do_reset();
        master_enable = 1'b1;
        repeat (4) @(negedge wb_clk);
        n_cmp++;
        if ({busy, start} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_no_request: busy/start got %b want 00", {busy, start});
        end
    endtask

    task automatic test_single_wrap();
        bit ok; bit wb;
        logic [3:0] g, w, ef, gu; logic [1:0] s; logic [31:0] a, ea;
        do_reset();
        set_cfg(0, 32'h1000, 16'd4);
        master_enable = 1'b1;
        request = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            ea = exp_addr(0);
            model_done(0, wb);
            last_m = 0;
            run_xfer(2, 1'b1, 1'b0, '0, 1'b0, 1'b0, ok, g, s, a, w, ef, gu);
            if (k == 4) request = '0;
            n_cmp++;
            if (!ok || a !== ea) begin
                n_bad++;
                $display("FAIL single_addr[%0d]: got %h (start=%0b) want %h", k, a, ok, ea);
            end
            n_cmp++;
            if (w !== (wb ? 4'b0001 : 4'b0000)) begin
                n_bad++;
                $display("FAIL single_wrap[%0d]: got %b want %b", k, w, wb ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok; bit wb; int ch;
        logic [3:0] g, w, ef, gu, eg; logic [1:0] s; logic [31:0] a, ea;
        do_reset();
        for (int i = 0; i < 4; i++) set_cfg(i, $urandom & 32'hFFFF_FFFC, 16'($urandom_range(1, 6)));
        master_enable = 1'b1;
        request = 4'hF;
        for (int k = 0; k < 8; k++) begin
            ch = pick(request, last_m);
            eg = 4'(1 << ch);
            ea = exp_addr(ch);
            model_done(ch, wb);
            last_m = ch;
            run_xfer($urandom_range(1, 3), 1'b1, 1'b0, '0, 1'b0, 1'b0, ok, g, s, a, w, ef, gu);
            if (k == 7) request = '0;
            n_cmp++;
            if (!ok || g !== eg || s !== 2'(ch)) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got grant %b sel %0d (start=%0b) want %b sel %0d", k, g, s, ok, eg, ch);
            end
            n_cmp++;
            if (a !== ea) begin
                n_bad++;
                $display("FAIL rr_addr[%0d]: got %h want %h", k, a, ea);
            end
            n_cmp++;
            if (gu !== 4'b0000 || w !== (wb ? eg : 4'b0000)) begin
                n_bad++;
                $display("FAIL rr_update[%0d]: grant %b wrap %b want grant 0000 wrap %b", k, gu, w, wb ? eg : 4'b0000);
            end
        end
    endtask

    task automatic test_error();
        bit ok; bit wb;
        logic [3:0] g, w, ef, gu; logic [1:0] s; logic [31:0] a;
        logic [31:0] ea [5];
        logic [3:0]  eef [5];
        bit d_v [5];
        bit e_v [5];
        logic [3:0] c_v [5];
        // ok, err, ok, done+err with simultaneous clear, ok
        d_v = '{1, 0, 1, 1, 1};
        e_v = '{0, 1, 0, 1, 0};
        c_v = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0};
        do_reset();
        set_cfg(2, 32'h2000_0000, 16'd5);
        master_enable = 1'b1;
        request = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            ea[k] = exp_addr(2);
            if (e_v[k]) err_m[2] = 1'b1;
            else model_done(2, wb);
            last_m = 2;
            eef[k] = err_m;
            run_xfer(1 + k % 2, d_v[k], e_v[k], c_v[k], 1'b0, 1'b0, ok, g, s, a, w, ef, gu);
            n_cmp++;
            if (!ok || a !== ea[k]) begin
                n_bad++;
                $display("FAIL err_addr[%0d]: got %h (start=%0b) want %h", k, a, ok, ea[k]);
            end
            n_cmp++;
            if (ef !== eef[k]) begin
                n_bad++;
                $display("FAIL err_flag[%0d]: got %b want %b", k, ef, eef[k]);
            end
            if (k == 1) begin
                request = '0;
                @(negedge wb_clk);
                err_clr = 4'b0100;
                @(negedge wb_clk);
                err_clr = '0;
                err_m = '0;
                n_cmp++;
                if (err_flag !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL err_clear: got %b want 0000", err_flag);
                end
                request = 4'b0100;
            end
        end
        request = '0;
    endtask

    task automatic test_enable_drop();
        bit ok; bit wb; int starts;
        logic [3:0] g, w, ef, gu; logic [1:0] s; logic [31:0] a, ea;
        do_reset();
        set_cfg(0, 32'h0000_0300, 16'd8);
        master_enable = 1'b1;
        request = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            ea = exp_addr(0);
            model_done(0, wb);
            last_m = 0;
            run_xfer(2, 1'b1, 1'b0, '0, k == 2, 1'b0, ok, g, s, a, w, ef, gu);
            n_cmp++;
            if (!ok || a !== ea || w !== 4'b0000) begin
                n_bad++;
                $display("FAIL en_xfer[%0d]: addr %h wrap %b (start=%0b) want %h wrap 0000", k, a, w, ok, ea);
            end
        end
        for (int i = 0; i < 4; i++) ptr_m[i] = 0;
        starts = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge wb_clk);
            if (start === 1'b1) starts++;
        end
        n_cmp++;
        if (starts != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL en_off_idle: starts %0d busy %b want 0 0", starts, busy);
        end
        master_enable = 1'b1;
        ea = exp_addr(0);
        model_done(0, wb);
        last_m = 0;
        run_xfer(1, 1'b1, 1'b0, '0, 1'b0, 1'b0, ok, g, s, a, w, ef, gu);
        request = '0;
        n_cmp++;
        if (!ok || a !== ea) begin
            n_bad++;
            $display("FAIL en_ptr_cleared: got %h (start=%0b) want %h", a, ok, ea);
        end
    endtask

    task automatic test_async_reset();
        bit ok; bit wb; int ch;
        logic [3:0] g, w, ef, gu; logic [1:0] s; logic [31:0] a, ea;
        do_reset();
        for (int i = 0; i < 4; i++) set_cfg(i, $urandom & 32'hFFFF_FFFC, 16'd4);
        master_enable = 1'b1;
        request = 4'hF;
        run_xfer(1, 1'b1, 1'b0, '0, 1'b0, 1'b0, ok, g, s, a, w, ef, gu);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge wb_clk);
            if (start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge wb_clk);
        n_cmp++;
        if (!ok || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_in_wait: start seen %0b busy %b want 1 1", ok, busy);
        end
        #2 wb_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({grant, start, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL arst_immediate: grant/start/busy got %b want 000000", {grant, start, busy});
        end
        do_reset();
        master_enable = 1'b1;
        request = 4'hF;
        ch = pick(request, last_m);
        ea = exp_addr(ch);
        model_done(ch, wb);
        last_m = ch;
        run_xfer(2, 1'b1, 1'b0, '0, 1'b0, 1'b0, ok, g, s, a, w, ef, gu);
        request = '0;
        n_cmp++;
        if (!ok || g !== 4'b0001 || a !== ea) begin
            n_bad++;
            $display("FAIL arst_first_grant: grant %b addr %h (start=%0b) want 0001 %h", g, a, ok, ea);
        end
    endtask

    task automatic test_random();
        bit ok; bit wb; bit e; bit d; int ch;
        logic [3:0] g, w, ef, gu, eg, ew, req; logic [1:0] s; logic [31:0] a, ea;
        do_reset();
        master_enable = 1'b1;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 4; i++) set_cfg(i, $urandom, 16'($urandom_range(0, 5)));
            req = 4'($urandom_range(1, 15));
            request = req;
            e = ($urandom_range(0, 3) == 0);
            d = !e || ($urandom_range(0, 1) == 1);
            ch = pick(req, last_m);
            eg = 4'(1 << ch);
            ea = exp_addr(ch);
            ew = '0;
            if (e) begin
                err_m = err_m | eg;
            end else begin
                model_done(ch, wb);
                if (wb) ew = eg;
            end
            last_m = ch;
            run_xfer($urandom_range(1, 4), d, e, '0, 1'b0, $urandom_range(0, 1) == 1,
                     ok, g, s, a, w, ef, gu);
            request = '0;
            n_cmp++;
            if (!ok || g !== eg || a !== ea) begin
                n_bad++;
                $display("FAIL rand_issue[%0d]: grant %b addr %h (start=%0b) want %b %h", k, g, a, ok, eg, ea);
            end
            n_cmp++;
            if (w !== ew || ef !== err_m) begin
                n_bad++;
                $display("FAIL rand_update[%0d]: wrap %b err %b want %b %b", k, w, ef, ew, err_m);
            end
        end
    endtask

`ifdef WB_DAQ_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; int cnt;
        logic [3:0] g, w, ef, gu; logic [1:0] s; logic [31:0] a;
        do_reset();
        set_cfg(0, 32'h0000_0040, 16'd4);
        master_enable = 1'b1;
        request = 4'b0001;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge wb_clk);
            if (start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge wb_clk);
            if (err_flag[0] === 1'b1) begin
                cnt = i;
                break;
            end
        end
        // ISSUE cycle, then 16 WAIT cycles, flag visible in UPDATE.
        n_cmp++;
        if (!ok || cnt != 17) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles (start=%0b) want 17", cnt, ok);
        end
        run_xfer(1, 1'b1, 1'b0, '0, 1'b0, 1'b0, ok, g, s, a, w, ef, gu);
        request = '0;
        n_cmp++;
        if (!ok || a !== 32'h0000_0040) begin
            n_bad++;
            $display("FAIL timeout_no_advance: got %h want 00000040", a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_wrap();
        test_round_robin();
        test_error();
        test_enable_drop();
        test_async_reset();
        test_random();
`ifdef WB_DAQ_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
